// File: rtl/unflat_if.sv
// unflat_if: serial-value input stream and multi-channel pixel output stream
interface unflat_if #(parameter int PIX_WIDTH = 8, parameter int DIMENSION = 8);
  logic [PIX_WIDTH-1:0] i_data;
  logic i_valid, i_sop, i_eop, o_ready;
  logic [DIMENSION-1:0][PIX_WIDTH-1:0] o_data;
  logic o_valid, o_sop, o_eop, i_ready, o_err;
  modport master (output i_data, i_valid, i_sop, i_eop, i_ready,
                  input o_ready, o_data, o_valid, o_sop, o_eop, o_err);
  modport slave (input i_data, i_valid, i_sop, i_eop, i_ready,
                 output o_ready, o_data, o_valid, o_sop, o_eop, o_err);
endinterface

// File: rtl/unflat.sv
// unflat: rebuilds a channel-major serial stream into a raster of DIMENSION-channel pixels
module unflat #(
  parameter int PIX_WIDTH = 8,
  parameter int DIMENSION = 8,
  parameter int img_width = 7,
  parameter int img_height = 7
) (
  input logic clk,
  input logic rst,
  input logic clk_en,
  unflat_if.slave s
);
  localparam int P = img_width * img_height;
  localparam int PW = $clog2(P + 1);
  localparam int CW = $clog2(DIMENSION + 1);
  localparam int PI = P > 1 ? $clog2(P) : 1;
  localparam int CI = DIMENSION > 1 ? $clog2(DIMENSION) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIMENSION - 1);
  typedef enum logic [1:0] {IDLE, FILL, RELEASE} state_t;
  state_t state, state_n;
  logic [PIX_WIDTH-1:0] mem [DIMENSION][P];
  logic [CW-1:0] ch, ch_n, wch;
  logic [PW-1:0] pix, pix_n, wpix, rd, rd_n, rd_sel;
  logic acc, hs, last, we, ld, ready_n, valid_n, err_n;
  always_comb begin
    acc = s.i_valid && s.o_ready;
    hs = s.o_valid && s.i_ready;
    wch = s.i_sop ? '0 : ch;
    wpix = s.i_sop ? '0 : pix;
    last = wch == C_LAST && wpix == P_LAST;
    we = acc && (state == FILL || s.i_sop);
    rd_sel = s.o_valid ? rd + PW'(1) : rd;
    state_n = state;
    ch_n = ch;
    pix_n = pix;
    rd_n = rd;
    ready_n = s.o_ready;
    valid_n = s.o_valid;
    err_n = 1'b0;
    ld = 1'b0;
    if (we) begin
      pix_n = wpix == P_LAST ? '0 : wpix + PW'(1);
      ch_n = wpix == P_LAST ? wch + CW'(1) : wch;
      state_n = last ? RELEASE : s.i_eop ? IDLE : FILL;
      ready_n = !last;
      rd_n = '0;
      err_n = (state == FILL && s.i_sop) || (last != s.i_eop);
    end
    // The last value lands in memory on the entry edge, so the first pixel loads one edge later
    if (state == RELEASE && (!s.o_valid || hs)) begin
      if (s.o_valid && rd == P_LAST) begin
        state_n = IDLE;
        valid_n = 1'b0;
        ready_n = 1'b1;
      end else begin
        ld = 1'b1;
        valid_n = 1'b1;
        rd_n = rd_sel;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      pix <= '0;
      rd <= '0;
      s.o_ready <= 1'b1;
      s.o_valid <= 1'b0;
      s.o_sop <= 1'b0;
      s.o_eop <= 1'b0;
      s.o_err <= 1'b0;
      s.o_data <= '0;
    end else if (clk_en) begin
      state <= state_n;
      ch <= ch_n;
      pix <= pix_n;
      rd <= rd_n;
      s.o_ready <= ready_n;
      s.o_valid <= valid_n;
      s.o_err <= err_n;
      s.o_sop <= ld ? rd_sel == '0 : valid_n && s.o_sop;
      s.o_eop <= ld ? rd_sel == P_LAST : valid_n && s.o_eop;
      if (ld)
        for (int c = 0; c < DIMENSION; c++) s.o_data[c] <= mem[c][PI'(rd_sel)];
    end
  always_ff @(posedge clk)
    if (clk_en && we) mem[CI'(wch)][PI'(wpix)] <= s.i_data;
endmodule

// File: tb/tb_unflat.sv
// tb_unflat: randomized frames for unflat checked against a frame-level reshape model
module tb_unflat;
  localparam int W = 8, D = 2, IW = 2, IH = 2, P = IW * IH, N = D * P;
  typedef struct packed {
    logic [D*W-1:0] data;
    logic sop;
    logic eop;
  } beat_t;
  typedef logic [W-1:0] vq_t[$];
  logic clk = 0, rst = 1, clk_en = 1;
  unflat_if #(.PIX_WIDTH(W), .DIMENSION(D)) bus ();
  unflat #(.PIX_WIDTH(W), .DIMENSION(D), .img_width(IW), .img_height(IH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .s(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, err_cnt = 0, rmode = 0, hs_cnt = 0;
  beat_t exp_q[$];
  beat_t held, e_b;
  logic hold = 0, last_en = 0, eop_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference reshape: pixel p carries value c*P+p of the frame in channel c
  task automatic expect_frame(input vq_t v);
    for (int p = 0; p < P; p++) begin
      beat_t b;
      for (int c = 0; c < D; c++) b.data[c*W +: W] = v[c*P + p];
      b.sop = p == 0;
      b.eop = p == P - 1;
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      eop_seen = 0;
    end else begin
      if (last_en && bus.o_err) err_cnt++;
      if (eop_seen) begin
        check("ready_after_eop", bus.o_ready, 1);
        check("valid_after_eop", bus.o_valid, 0);
        eop_seen = 0;
      end
      if (hold) check("hold", {bus.o_valid, bus.o_data, bus.o_sop, bus.o_eop}, {1'b1, held});
      hold = 0;
      if (bus.o_valid && !(bus.i_ready && clk_en)) begin
        hold = 1;
        held = {bus.o_data, bus.o_sop, bus.o_eop};
      end
      if (bus.o_valid && bus.i_ready && clk_en) begin
        if (exp_q.size() == 0) check("unexpected_beat", bus.o_valid, 0);
        else begin
          e_b = exp_q.pop_front();
          check("beat", {bus.o_data, bus.o_sop, bus.o_eop}, e_b);
          hs_cnt++;
          eop_seen = bus.o_eop;
        end
      end
    end
    last_en = clk_en;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.i_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input logic s, input logic e);
    logic acc = 0;
    bus.i_data = v;
    bus.i_valid = 1;
    bus.i_sop = s;
    bus.i_eop = e;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.o_ready && clk_en;
      tick();
    end
    if (!acc) check("accept_timeout", acc, 1);
    bus.i_valid = 0;
    bus.i_sop = 0;
    bus.i_eop = 0;
  endtask

  task automatic send_frame(input vq_t v);
    for (int i = 0; i < v.size(); i++) send(v[i], i == 0, i == v.size() - 1);
  endtask

  task automatic rand_vals(output vq_t v, input int n);
    v.delete();
    for (int i = 0; i < n; i++) v.push_back(W'($urandom));
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.o_valid || !bus.o_ready) && k < 300) begin
      tick();
      k++;
    end
    check("drain_timeout", k < 300, 1);
  endtask

  initial begin
    vq_t v;
    int e0;
    bus.i_data = 0;
    bus.i_valid = 0;
    bus.i_sop = 0;
    bus.i_eop = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.o_ready, 1);
    check("rst_valid", bus.o_valid, 0);
    check("rst_flags", {bus.o_sop, bus.o_eop, bus.o_err}, 0);
    check("rst_data", bus.o_data, 0);
    rst = 0;
    tick();
    // Directed frame 0..7 with latency checks
    v.delete();
    for (int i = 0; i < N; i++) v.push_back(W'(i));
    expect_frame(v);
    send_frame(v);
    @(negedge clk);
    check("ready_in_release", bus.o_ready, 0);
    check("latency_valid_low", bus.o_valid, 0);
    @(negedge clk);
    check("latency_valid_high", bus.o_valid, 1);
    tick();
    drain();
    // Random frames under random back-pressure
    rmode = 1;
    repeat (4) begin
      rand_vals(v, N);
      expect_frame(v);
      send_frame(v);
      drain();
    end
    rmode = 0;
    // Early eop on value 5, then o_err held across a disabled gap
    e0 = err_cnt;
    rand_vals(v, 6);
    send_frame(v);
    clk_en = 0;
    @(negedge clk);
    check("early_eop_err", bus.o_err, 1);
    check("early_eop_no_valid", bus.o_valid, 0);
    tick();
    @(negedge clk);
    check("err_hold_disabled", bus.o_err, 1);
    tick();
    clk_en = 1;
    tick();
    @(negedge clk);
    check("err_clears", bus.o_err, 0);
    check("early_eop_idle", {bus.o_ready, bus.o_valid}, 2'b10);
    check("early_eop_err_count", err_cnt - e0, 1);
    tick();
    v.delete();
    for (int i = 0; i < N; i++) v.push_back(W'(10 + i));
    expect_frame(v);
    send_frame(v);
    drain();
    // Restart by a second sop at value 3
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send(W'($urandom), i == 0, 0);
    rand_vals(v, N);
    expect_frame(v);
    send_frame(v);
    drain();
    check("restart_err_count", err_cnt - e0, 1);
    // Input beats during RELEASE are ignored
    rmode = 2;
    rand_vals(v, N);
    expect_frame(v);
    send_frame(v);
    bus.i_valid = 1;
    bus.i_sop = 1;
    bus.i_eop = 1;
    for (int i = 0; i < 4; i++) begin
      bus.i_data = W'($urandom);
      @(negedge clk);
      check("ready_low_release", bus.o_ready, 0);
      tick();
    end
    bus.i_valid = 0;
    bus.i_sop = 0;
    bus.i_eop = 0;
    rmode = 0;
    drain();
    // Beats without sop in IDLE are dropped silently
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send(W'($urandom), 0, i == 2);
    @(negedge clk);
    check("idle_drop_no_valid", bus.o_valid, 0);
    tick();
    rand_vals(v, N);
    expect_frame(v);
    send_frame(v);
    drain();
    check("idle_drop_no_err", err_cnt - e0, 0);
    // Reset mid-RELEASE after two beats
    rand_vals(v, N);
    expect_frame(v);
    send_frame(v);
    e0 = hs_cnt + 2;
    for (int k = 0; k < 50 && hs_cnt < e0; k++) tick();
    check("two_beats_before_rst", hs_cnt >= e0, 1);
    rst = 1;
    #1;
    check("rst_mid_valid", bus.o_valid, 0);
    check("rst_mid_ready", bus.o_ready, 1);
    exp_q.delete();
    tick();
    rst = 0;
    tick();
    rand_vals(v, N);
    expect_frame(v);
    send_frame(v);
    drain();
    // clk_en gaps mid-fill and mid-release
    rand_vals(v, N);
    expect_frame(v);
    for (int i = 0; i < N / 2; i++) send(v[i], i == 0, 0);
    clk_en = 0;
    bus.i_valid = 1;
    bus.i_sop = 1;
    for (int i = 0; i < 3; i++) begin
      bus.i_data = W'($urandom);
      tick();
    end
    @(negedge clk);
    check("gap_no_valid", bus.o_valid, 0);
    tick();
    bus.i_valid = 0;
    bus.i_sop = 0;
    clk_en = 1;
    for (int i = N / 2; i < N; i++) send(v[i], 0, i == N - 1);
    tick();
    tick();
    clk_en = 0;
    repeat (3) tick();
    clk_en = 1;
    drain();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
